fetch_stage: RTL

Instruction-fetch stage of the MIPS datapath, directly upstream of decode and the ULA. Owns the program counter, drives the instruction memory address, and registers the fetched word into an IF/ID pipeline register with a valid flag. Supports decode back-pressure (stall), pipeline flush, and a branch/jump redirect from downstream stages, and keeps a retired-fetch counter for bring-up.

---
 rtl/fetch_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the MIPS datapath.
//
// Owns the program counter and drives the instruction memory address from it. The fetched word
// is registered into an IF/ID pipeline register with a valid flag. The stage supports decode
// back-pressure (stall), pipeline flush and a branch/jump redirect. A retired-fetch counter is
// kept for bring-up.
//
// Build option:
//   FETCH_MISALIGN_TRAP_EN  When defined, a redirect to a non-word-aligned target loads
//                           EXC_VECTOR and pulses misalign_trap. When undefined, the low two
//                           target bits are dropped and misalign_trap is constant 0.
//
// Parameters:
//   RESET_PC        PC value loaded on reset
//   EXC_VECTOR      PC loaded on a misaligned redirect (trap build only)
//
// Ports:
//   clock           in   rising-edge clock
//   reset           in   asynchronous, active-high reset
//   stall           in   decode not ready; hold PC and IF/ID register
//   flush           in   invalidate IF/ID contents
//   redirect        in   taken branch/jump this cycle (highest priority)
//   redirect_target in   next PC when redirect=1
//   imem_addr       out  instruction memory address (combinational copy of pc)
//   imem_data       in   instruction word at imem_addr (combinational read)
//   pc              out  current PC register
//   id_instr        out  registered instruction to decode
//   id_pc4          out  registered PC+4 of id_instr
//   id_valid        out  id_instr holds a real instruction
//   fetch_count     out  count of instructions accepted into IF/ID
//   misalign_trap   out  one-cycle pulse on a misaligned redirect

module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic [31:0] pc,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc4,
   output logic        id_valid,
   output logic [31:0] fetch_count,
   output logic        misalign_trap
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [31:0] count_q, count_d;
   logic        trap_q, trap_d;

   logic [31:0] pc_plus4;
   logic [31:0] redirect_pc;
   logic        redirect_misaligned;

   // Absorbs bits that only the trap build consumes, so both builds lint the same way.
   logic        unused_cfg;
   assign unused_cfg = ^{redirect_target[1:0], EXC_VECTOR};

   // Modulo 2^32: 32'hFFFF_FFFC advances to 0.
   assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign redirect_misaligned = (redirect_target[1:0] != 2'b00);
   assign redirect_pc         = redirect_misaligned ? EXC_VECTOR : redirect_target;
`else
   assign redirect_misaligned = 1'b0;
   assign redirect_pc         = {redirect_target[31:2], 2'b00};
`endif

   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      count_d = count_q;
      trap_d  = 1'b0;

      if (redirect) begin
         // Wrong-path word in IF/ID is dropped; stall and flush do not matter here.
         pc_d    = redirect_pc;
         instr_d = 32'h0000_0000;
         valid_d = 1'b0;
         trap_d  = redirect_misaligned;
      end else if (flush) begin
         instr_d = 32'h0000_0000;
         valid_d = 1'b0;
         if (!stall) begin
            pc_d = pc_plus4;
         end
      end else if (!stall) begin
         pc_d    = pc_plus4;
         instr_d = imem_data;
         pc4_d   = pc_plus4;
         valid_d = 1'b1;
         count_d = count_q + 32'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         instr_q <= 32'h0000_0000;
         pc4_q   <= 32'h0000_0000;
         valid_q <= 1'b0;
         count_q <= 32'h0000_0000;
         trap_q  <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         count_q <= count_d;
         trap_q  <= trap_d;
      end
   end

   assign imem_addr     = pc_q;
   assign pc            = pc_q;
   assign id_instr      = instr_q;
   assign id_pc4        = pc4_q;
   assign id_valid      = valid_q;
   assign fetch_count   = count_q;
   assign misalign_trap = trap_q;

endmodule
